// File: rtl/turn_signal_fsm.sv
// Turn-signal tail-light sequencer: switch sync, step prescaler, state reg.
// Optional hazard blink from IDLE on both switches: define TURN_HAZARD_EN.
module turn_signal_fsm #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       Rn,
  input  logic [1:0] SW,
  output logic [2:0] CurrentState,
  output logic [2:0] NextState,
  output logic       turn_side,
  output logic       tick
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    HAZ  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             side_q, side_d;
  state_e           nxt;
  logic             side_n;
  logic [1:0]       sw_s;
  logic [1:0]       own_req;

  assign sw_s = sync2_q;

  // Two-flop synchroniser and free-running step prescaler.
  always_comb begin
    sync1_d = SW;
    sync2_d = sync1_q;
    tick    = (cnt_q == LAST);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
  end

  // Next-state decode; state and side only advance on a step tick.
  always_comb begin
    nxt     = IDLE;
    side_n  = side_q;
    own_req = side_q ? 2'b10 : 2'b01;
    case (state_q)
      IDLE: begin
        if (sw_s == 2'b01) begin
          nxt    = S1;
          side_n = 1'b0;
        end else if (sw_s == 2'b10) begin
          nxt    = S1;
          side_n = 1'b1;
`ifdef TURN_HAZARD_EN
        end else if (sw_s == 2'b11) begin
          nxt = HAZ;
`endif
        end else begin
          nxt = IDLE;
        end
      end
      S1: nxt = S2;
      S2: nxt = S3;
      S3: nxt = (sw_s == own_req) ? S1 : IDLE;
      default: nxt = IDLE;
    endcase
    state_d = tick ? nxt : state_q;
    side_d  = tick ? side_n : side_q;
  end

  // State, side, prescaler and synchroniser registers.
  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      cnt_q   <= '0;
      state_q <= IDLE;
      side_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      side_q  <= side_d;
    end
  end

  assign CurrentState = state_q;
  assign NextState    = nxt;
  assign turn_side    = side_q;

endmodule

// File: tb/tb_turn_signal_fsm.sv
// Bench for turn_signal_fsm: directed phases plus random switch activity.
// Reference model works from sampled switch history and edge counts.
module tb_turn_signal_fsm;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       Rn  = 1'b0;
  logic [1:0] SW  = 2'b00;
  logic [2:0] CurrentState;
  logic [2:0] NextState;
  logic       turn_side;
  logic       tick;

  int checks = 0;
  int errors = 0;

  int         m_state;
  int         m_side;
  int         m_edges;
  logic [1:0] m_hist[$];

  turn_signal_fsm #(.TICK_DIV(TD), .CNT_W(16)) dut (
    .clk(clk),
    .Rn(Rn),
    .SW(SW),
    .CurrentState(CurrentState),
    .NextState(NextState),
    .turn_side(turn_side),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Spec-level transition rule: returns {next state, next side}.
  function automatic void rule(input int st, input int sd,
                               input logic [1:0] s,
                               output int nst, output int nsd);
    nst = 0;
    nsd = sd;
    if (st == 0) begin
      if (s == 2'b01) begin nst = 1; nsd = 0; end
      else if (s == 2'b10) begin nst = 1; nsd = 1; end
`ifdef TURN_HAZARD_EN
      else if (s == 2'b11) nst = 4;
`endif
    end else if (st == 1) nst = 2;
    else if (st == 2) nst = 3;
    else if (st == 3) begin
      if ((sd == 0 && s == 2'b01) || (sd == 1 && s == 2'b10)) nst = 1;
    end
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_side  = 0;
    m_edges = 0;
    m_hist  = {};
    m_hist.push_back(2'b00);
    m_hist.push_back(2'b00);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check current outputs, apply sw, advance one clock and the model.
  task automatic cycle(input logic [1:0] sw);
    int nst, nsd;
    bit mtick;
    mtick = ((m_edges % TD) == TD - 1);
    rule(m_state, m_side, m_hist[0], nst, nsd);
    chk("state", int'(CurrentState), m_state);
    chk("side", int'(turn_side), m_side);
    chk("tick", int'(tick), int'(mtick));
    chk("next", int'(NextState), nst);
    SW = sw;
    @(posedge clk);
    if (mtick) begin
      m_state = nst;
      m_side  = nsd;
    end
    void'(m_hist.pop_front());
    m_hist.push_back(sw);
    m_edges++;
    @(negedge clk);
  endtask

  task automatic run(input logic [1:0] sw, input int n);
    for (int i = 0; i < n; i++) cycle(sw);
  endtask

  // Hold sw until the model reaches the target state, bounded.
  task automatic hold_until(input logic [1:0] sw, input int st,
                            input int sd, input string tag);
    int k;
    k = 0;
    while (!(m_state == st && (sd < 0 || m_side == sd)) && k < 60) begin
      cycle(sw);
      k++;
    end
    chk(tag, m_state, st);
  endtask

  initial begin
    int hold;
    logic [1:0] rsw;
    model_reset();
    #3;
    chk("rst_state", int'(CurrentState), 0);
    chk("rst_side", int'(turn_side), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_next", int'(NextState), 0);
    #7;
    Rn = 1'b1;

    run(2'b00, 12);
    run(2'b01, 30);
    chk("left_side", int'(turn_side), 0);

    hold_until(2'b10, 2, 1, "reach_r_s2");
    chk("right_side", int'(turn_side), 1);
    run(2'b00, 20);
    chk("release_idle", int'(CurrentState), 0);

    hold_until(2'b01, 2, 0, "reach_l_s2");
    run(2'b10, 24);
    chk("swap_side", int'(turn_side), 1);

    hold_until(2'b01, 1, 0, "reach_l_s1");
    hold_until(2'b01, 3, 0, "reach_l_s3");
    #1 Rn = 1'b0;
    #2;
    chk("async_state", int'(CurrentState), 0);
    chk("async_side", int'(turn_side), 0);
    Rn = 1'b1;
    model_reset();
    run(2'b01, 20);

    run(2'b00, 8);
    run(2'b11, 24);

    for (int r = 0; r < 60; r++) begin
      rsw  = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 14);
      run(rsw, hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
